instr_fetch_store: RTL

Parametrised instruction store with a built-in fetch sequencer. It holds control words of the form {op, A, B} and is loadable at run time through a write port. On a start pulse it streams words out from a given address over a valid/ready handshake until it reaches a halt word (op = 0) or has walked the whole store. It sits between the program loader and the datapath controller, replacing the fixed, combinationally-read instruction table.

---
 rtl/instr_fetch_store_pkg.sv | 22 ++
 rtl/instr_fetch_store_ram.sv | 26 ++
 rtl/instr_fetch_store.sv | 96 +++++++++
 3 files changed

// File: rtl/instr_fetch_store_pkg.sv
// Shared widths, opcodes and FSM encoding for the instruction store / fetch sequencer.
package instr_fetch_store_pkg;

  localparam int ABITS_DEF = 6;
  localparam int AW_DEF    = 4;
  localparam int BW_DEF    = 4;

  localparam logic OP_HALT = 1'b0;
  localparam logic OP_EXEC = 1'b1;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_e;

  // Word layout is {op, A, B}: B at [bw-1:0], A at [aw+bw-1:bw], op at the top bit.
  function automatic int dbits(input int aw, input int bw);
    return 1 + aw + bw;
  endfunction

  function automatic int op_pos(input int aw, input int bw);
    return aw + bw;
  endfunction

endpackage

// File: rtl/instr_fetch_store_ram.sv
// DEPTH x DBITS store: one synchronous write port, one registered read port.
module instr_store_ram #(
  parameter int ABITS = 6,
  parameter int DBITS = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata
);

  logic [DBITS-1:0] mem [2**ABITS];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Read register doubles as the presented-word register, so it holds when re=0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/instr_fetch_store.sv
// Loadable instruction store with a fetch sequencer streaming {op,A,B} words over valid/ready.
module instr_fetch_store
  import instr_fetch_store_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int AW    = AW_DEF,
  parameter int BW    = BW_DEF,
  localparam int DBITS = dbits(AW, BW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [ABITS-1:0] ld_addr,
  input  logic [DBITS-1:0] ld_data,
  input  logic             start,
  input  logic [ABITS-1:0] start_addr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             instr_op,
  output logic [AW-1:0]    instr_a,
  output logic [BW-1:0]    instr_b,
  output logic [ABITS-1:0] instr_pc,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int OPB = op_pos(AW, BW);

  state_e           state, nxt;
  logic [ABITS-1:0] pc, cnt;
  logic [DBITS-1:0] rdata;
  logic             re, we, is_exec, accept, last;

  assign is_exec = (rdata[OPB] == OP_EXEC);
  assign accept  = (state == PRESENT) && is_exec && instr_ready;
  assign last    = (cnt == '1);

  instr_store_ram #(.ABITS(ABITS), .DBITS(DBITS)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (re),
    .raddr (pc),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = FETCH;
      FETCH:   nxt = PRESENT;
      PRESENT: if (!is_exec)   nxt = IDLE;
               else if (accept) nxt = last ? IDLE : FETCH;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    re          = (state == FETCH);
    we          = ld_en && (state == IDLE);
    instr_valid = (state == PRESENT) && is_exec;
    done        = (state == PRESENT) && (!is_exec || (accept && last));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc      <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else if (state == IDLE && start) begin
      pc      <= start_addr;
      cnt     <= '0;
      overrun <= 1'b0;
    end else if (accept) begin
      // Last accept of a full walk leaves pc on the final word; overrun flags the missing halt.
      if (last) overrun <= 1'b1;
      else begin
        pc  <= pc + ABITS'(1);
        cnt <= cnt + ABITS'(1);
      end
    end

  assign instr_pc = pc;
  assign instr_op = rdata[OPB];
  assign instr_a  = rdata[OPB-1:BW];
  assign instr_b  = rdata[BW-1:0];

endmodule
